// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequential carry-lookahead add/sub unit.
// Holds the FSM encoding and the index-width helper.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int idx_width(input int s);
        int r;
        r = clog2(s);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_slice.sv
// Combinational W-bit carry-lookahead adder with carry-in.
// Each carry is the flattened generate/propagate sum-of-products.
module cla_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin : lookahead
        logic prod;
        logic acc;
        c    = '0;
        c[0] = cin;
        prod = 1'b1;
        acc  = 1'b0;
        for (int i = 0; i < W; i++) begin
            prod = 1'b1;
            acc  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = acc | (cin & prod);
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle N-bit add/subtract that walks one W-bit CLA slice over N/W
// cycles, chaining the carry through a register, with valid/ready on both sides.
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow,
    output logic         busy
);

    localparam int S  = (W < 1) ? 1 : N / W;
    localparam int KW = idx_width(S);

    if (W < 1 || (N % W) != 0) begin : g_bad_params
        $error("cla_seq_adder_ctrl: N must be a positive multiple of W");
    end

    state_t        state;
    logic [KW-1:0] k;
    logic          cy;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;

    logic [W-1:0]  sx;
    logic [W-1:0]  sy;
    logic [W-1:0]  ss;
    logic          scout;
    logic          last;
    logic          ovf;

    always_comb begin
        sx = a_r[k*W +: W];
        sy = b_r[k*W +: W];
    end

    cla_slice #(
        .W(W)
    ) u_slice (
        .x   (sx),
        .y   (sy),
        .cin (cy),
        .s   (ss),
        .cout(scout)
    );

    assign last = (k == KW'(S - 1));
    // Only meaningful on the top slice, where ss[W-1] is the result sign.
    assign ovf  = (a_r[N-1] == b_r[N-1]) && (ss[W-1] != a_r[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            cy        <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b ^ {N{sub}};
                        cy       <= sub;
                        k        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[k*W +: W] <= ss;
                    cy            <= scout;
                    if (last) begin
                        k         <= '0;
                        state     <= DONE;
                        carry_out <= scout;
                        overflow  <= ovf;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed plus random checks of the sequential add/sub unit against an
// arithmetic reference model.
module tb_cla_seq_adder_ctrl;

    localparam int N = 64;
    localparam int W = 16;
    localparam int S = N / W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int total;
    int bad;

    cla_seq_adder_ctrl #(
        .N(N),
        .W(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and widened signed arithmetic.
    task automatic model(input logic [63:0] x, input logic [63:0] y,
                         input logic s, output logic [63:0] rs,
                         output logic rc, output logic ro);
        logic [64:0]        u;
        logic signed [64:0] r;
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            rc = (x >= y);
            r  = $signed({x[63], x}) - $signed({y[63], y});
        end else begin
            u  = {1'b0, x} + {1'b0, y};
            rc = u[64];
            r  = $signed({x[63], x}) + $signed({y[63], y});
        end
        rs = u[63:0];
        ro = (r > 65'sh0_7FFF_FFFF_FFFF_FFFF) ||
             (r < -65'sh0_8000_0000_0000_0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs after handshake, check latency and result,
    // optionally stall the consumer before retiring.
    task automatic do_op(input string tag, input logic [63:0] x,
                         input logic [63:0] y, input logic s,
                         input int stall);
        logic [63:0] es;
        logic        ec;
        logic        eo;
        logic [63:0] hs;
        int          n;
        model(x, y, s, es, ec, eo);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".ready"}, 64'(in_ready), 64'd1);
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        sub      = 1'($urandom);
        n        = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(S));
        check({tag, ".sum"}, sum, es);
        check({tag, ".co"}, 64'(carry_out), 64'(ec));
        check({tag, ".ov"}, 64'(overflow), 64'(eo));
        if (stall > 0) begin
            hs = sum;
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                a        = {$urandom, $urandom};
                b        = {$urandom, $urandom};
                tick();
            end
            check({tag, ".hold_v"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_s"}, sum, hs);
            check({tag, ".hold_r"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_b"}, 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".ret_v"}, 64'(out_valid), 64'd0);
        check({tag, ".ret_r"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #23;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.sum", sum, 64'd0);
        check("rst.co", 64'(carry_out), 64'd0);
        check("rst.ov", 64'(overflow), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        do_op("add3", 64'd3, 64'd3, 1'b0, 0);
        do_op("add444", 64'd112233, 64'd332211, 1'b0, 0);
        do_op("add2000", 64'd1000, 64'd1000, 1'b0, 0);
        do_op("add196", 64'd123, 64'd73, 1'b0, 0);
        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        do_op("sub5m7", 64'd5, 64'd7, 1'b1, 0);
        do_op("sub7m5", 64'd7, 64'd5, 1'b1, 0);
        do_op("subovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
        do_op("bp", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              1'b0, 10);

        // Early out_ready must not retire anything before the result exists.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("early.ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 4 == 1) y = ~x;
            if (i % 4 == 2) y = x;
            do_op($sformatf("rnd%0d", i), x, y, 1'($urandom),
                  int'($urandom_range(0, 3)));
        end

        // Reset during the second RUN cycle with a carry in flight.
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 64'd1;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst.idle", 64'(out_valid), 64'd0);
        do_op("post_rst", 64'd246, 64'd562, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
